// File: rtl/prog_seq_counter.sv
// -----------------------------------------------------------------------------
// prog_seq_counter
//
// Purpose:
//   Programmable sequence counter. It walks an index through a run-time
//   writable table of WIDTH-bit values and presents the selected value on q.
//   The walk can go forward or in reverse. The active length is set by
//   len_m1, the index of the last active entry. At the end of the sequence the
//   counter either wraps or, in one-shot mode, halts with done set.
//
// Parameters:
//   WIDTH     bits per sequence value
//   DEPTH     number of table entries (power of two, >= 2)
//   IDX_W     log2(DEPTH)
//   RESET_SEQ packed table contents loaded on reset, entry 0 in the LSBs
//
// Ports:
//   clk      in   rising-edge clock
//   clear    in   asynchronous reset, active low
//   en       in   advance one step per clock when high
//   dir      in   0 = forward (idx+1), 1 = reverse (idx-1)
//   mode     in   0 = wrap, 1 = one-shot (halt at sequence end)
//   len_m1   in   index of the last active table entry
//   sync_clr in   synchronous restart; overrides en
//   wr_en    in   table write strobe
//   wr_addr  in   table write index
//   wr_data  in   table write value
//   q        out  current sequence value (registered)
//   idx      out  current table index (registered)
//   tc       out  terminal count (combinational from idx, dir, len_m1)
//   done     out  one-shot halted flag (registered)
// -----------------------------------------------------------------------------
module prog_seq_counter #(
  parameter int                     WIDTH     = 4,
  parameter int                     DEPTH     = 8,
  parameter int                     IDX_W     = 3,
  parameter logic [WIDTH*DEPTH-1:0] RESET_SEQ = 32'hF9DA8740
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic [IDX_W-1:0] len_m1,
  input  logic             sync_clr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] q,
  output logic [IDX_W-1:0] idx,
  output logic             tc,
  output logic             done
);

  localparam logic [IDX_W-1:0] IDX_ZERO = '0;
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  // The control state is small. The counter is either running or parked
  // after a one-shot pass has finished.
  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [WIDTH-1:0] table_q [DEPTH];
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic [WIDTH-1:0] q_q;
  logic             load;
  logic             step;
  logic             at_end;

  // "End of sequence" depends on direction. Going forward, the end is the
  // last active index or anything beyond it, because len_m1 may have shrunk
  // under a running counter. Going in reverse, the end is index 0. The same
  // term drives the tc output.
  assign at_end = dir ? (idx_q == IDX_ZERO) : (idx_q >= len_m1);

  // A step is only taken while running. In the parked state en is ignored
  // until a restart or reset.
  assign step = en && (state_q == ST_RUN);

  // State register for the run/done control.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A restart always returns to running. A one-shot step
  // taken at the end of the sequence parks the counter instead of wrapping.
  always_comb begin
    state_d = state_q;
    if (sync_clr) begin
      state_d = ST_RUN;
    end else if (step && mode && at_end) begin
      state_d = ST_DONE;
    end
  end

  // Output decode for the control state.
  always_comb begin
    done = (state_q == ST_DONE);
  end

  // Next index selection, with restart taking priority over stepping.
  // 'load' marks every edge where q must be refreshed from the table.
  // This includes a one-shot halting step, where the index itself stays put.
  // In reverse, an index left beyond a shortened len_m1 is pulled back onto
  // the last active entry rather than walking down through dead entries.
  always_comb begin
    idx_d = idx_q;
    load  = 1'b0;
    if (sync_clr) begin
      idx_d = dir ? len_m1 : IDX_ZERO;
      load  = 1'b1;
    end else if (step) begin
      load = 1'b1;
      if (at_end) begin
        if (!mode) begin
          idx_d = dir ? len_m1 : IDX_ZERO;
        end
      end else if (dir) begin
        idx_d = (idx_q > len_m1) ? len_m1 : (idx_q - IDX_ONE);
      end else begin
        idx_d = idx_q + IDX_ONE;
      end
    end
  end

  // Index and value registers. q reads table_q through a non-blocking
  // update. A write landing on the same entry in this cycle is therefore not
  // seen yet, and q gets the old contents.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      idx_q <= IDX_ZERO;
      q_q   <= RESET_SEQ[WIDTH-1:0];
    end else if (load) begin
      idx_q <= idx_d;
      q_q   <= table_q[idx_d];
    end
  end

  // Sequence table storage. It reloads from RESET_SEQ on reset and accepts a
  // write on any edge, whatever the counter is doing.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= RESET_SEQ[i*WIDTH +: WIDTH];
      end
    end else if (wr_en) begin
      table_q[wr_addr] <= wr_data;
    end
  end

  // Output mapping.
  always_comb begin
    q   = q_q;
    idx = idx_q;
    tc  = at_end;
  end

endmodule

// File: tb/tb_prog_seq_counter.sv
// -----------------------------------------------------------------------------
// tb_prog_seq_counter
//
// Purpose:
//   Self-checking bench for prog_seq_counter. A driver issues one set of
//   inputs per clock and pushes the predicted post-edge outputs into a
//   scoreboard queue. A separate monitor pops one entry after each rising
//   edge and compares it against q, idx, tc and done.
// -----------------------------------------------------------------------------
module tb_prog_seq_counter;

  logic       clk;
  logic       clear;
  logic       en;
  logic       dir;
  logic       mode;
  logic [2:0] len_m1;
  logic       sync_clr;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic [3:0] q;
  logic [2:0] idx;
  logic       tc;
  logic       done;

  prog_seq_counter #(
    .WIDTH    (4),
    .DEPTH    (8),
    .IDX_W    (3),
    .RESET_SEQ(32'hF9DA8740)
  ) dut (
    .clk     (clk),
    .clear   (clear),
    .en      (en),
    .dir     (dir),
    .mode    (mode),
    .len_m1  (len_m1),
    .sync_clr(sync_clr),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .q       (q),
    .idx     (idx),
    .tc      (tc),
    .done    (done)
  );

  typedef struct {
    int         id;
    logic [3:0] q;
    logic [2:0] idx;
    logic       tc;
    logic       done;
  } exp_t;

  exp_t sb[$];

  int n_vectors     = 0;
  int n_miscompares = 0;
  int n_issued      = 0;

  // Reference model. It is a plain array plus a position and a halted flag.
  int m_tbl [8];
  int m_idx;
  int m_q;
  bit m_done;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop if the run somehow stalls.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "[TB] timeout");
  end

  // Reset the model to the power-on sequence 0,4,7,8,10,13,9,15.
  task automatic modelReset();
    int init [8] = '{0, 4, 7, 8, 10, 13, 9, 15};
    for (int i = 0; i < 8; i++) m_tbl[i] = init[i];
    m_idx  = 0;
    m_q    = m_tbl[0];
    m_done = 0;
  endtask

  // Apply the rules of one clock edge to the model.
  task automatic modelEdge(input bit i_en, input bit i_dir, input bit i_mode,
                           input int len, input bit i_sclr, input bit i_wr,
                           input int addr, input int data);
    bit moved;
    moved = 0;
    if (i_sclr) begin
      m_idx  = i_dir ? len : 0;
      m_done = 0;
      moved  = 1;
    end else if (i_en && !m_done) begin
      moved = 1;
      if (!i_dir) begin
        if (m_idx < len) m_idx = m_idx + 1;
        else if (!i_mode) m_idx = 0;
        else m_done = 1;
      end else begin
        if (m_idx == 0) begin
          if (!i_mode) m_idx = len;
          else m_done = 1;
        end else begin
          m_idx = (m_idx - 1 < len) ? m_idx - 1 : len;
        end
      end
    end
    if (moved) m_q = m_tbl[m_idx];
    if (i_wr) m_tbl[addr] = data;
  endtask

  // Drive one cycle's inputs after the previous edge and predict the result
  // of the next edge. With pulse set, clear is dropped briefly between edges.
  // With c_lvl low, clear is held low through the edge.
  task automatic applyStimulus(input bit c_lvl, input bit pulse, input bit i_en,
                               input bit i_dir, input bit i_mode, input int len,
                               input bit i_sclr, input bit i_wr, input int addr,
                               input int data);
    exp_t e;
    @(posedge clk);
    #2;
    clear    = c_lvl;
    en       = i_en;
    dir      = i_dir;
    mode     = i_mode;
    len_m1   = 3'(len);
    sync_clr = i_sclr;
    wr_en    = i_wr;
    wr_addr  = 3'(addr);
    wr_data  = 4'(data);
    if (pulse) begin
      #1 clear = 1'b0;
      #1 clear = 1'b1;
    end
    if (pulse || !c_lvl) modelReset();
    if (c_lvl) modelEdge(i_en, i_dir, i_mode, len, i_sclr, i_wr, addr, data);
    e.id   = n_issued;
    e.q    = 4'(m_q);
    e.idx  = 3'(m_idx);
    e.tc   = i_dir ? (m_idx == 0) : (m_idx >= len);
    e.done = m_done;
    sb.push_back(e);
    n_issued++;
  endtask

  // Short form for an ordinary cycle with no write and no reset activity.
  task automatic run(input bit i_en, input bit i_dir, input bit i_mode,
                     input int len, input bit i_sclr);
    applyStimulus(1, 0, i_en, i_dir, i_mode, len, i_sclr, 0, 0, 0);
  endtask

  task automatic checkOutput(input string nm, input int id,
                             input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s vec %0d: got %0d expected %0d", nm, id, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry is consumed just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_vectors++;
        checkOutput("q",    e.id, 32'(q),    32'(e.q));
        checkOutput("idx",  e.id, 32'(idx),  32'(e.idx));
        checkOutput("tc",   e.id, 32'(tc),   32'(e.tc));
        checkOutput("done", e.id, 32'(done), 32'(e.done));
      end
    end
  end

  // Driver: directed scenarios first, then a randomized run.
  initial begin
    clear = 1'b0; en = 1'b0; dir = 1'b0; mode = 1'b0; len_m1 = 3'd7;
    sync_clr = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 4'd0;
    modelReset();
    $display("[TB] start");

    // Reset held across edges, then a full forward wrap.
    applyStimulus(0, 0, 1, 0, 0, 7, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 7, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) run(1, 0, 0, 7, 0);

    // Reverse from reset: the first step goes to the last entry.
    applyStimulus(1, 1, 1, 1, 0, 7, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) run(1, 1, 0, 7, 0);

    // One-shot over four entries, en ignored once done, then a restart.
    applyStimulus(1, 1, 1, 0, 1, 3, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) run(1, 0, 1, 3, 0);
    run(1, 0, 1, 3, 1);
    run(0, 0, 1, 3, 0);

    // A write to the entry being stepped onto returns old data; after a wrap
    // the new value shows.
    applyStimulus(1, 1, 1, 0, 0, 7, 0, 1, 1, 2);
    for (int i = 0; i < 8; i++) run(1, 0, 0, 7, 0);

    // en gating, then a restart with en also high.
    run(1, 0, 0, 7, 0);
    run(0, 0, 0, 7, 0);
    run(0, 0, 0, 7, 0);
    run(1, 0, 0, 7, 0);
    run(1, 0, 0, 7, 1);

    // Move to index 5, then clear mid-sequence so the table reloads.
    run(1, 0, 0, 7, 1);
    for (int i = 0; i < 5; i++) run(1, 0, 0, 7, 0);
    applyStimulus(1, 1, 1, 0, 0, 7, 0, 0, 0, 0);
    run(1, 0, 0, 7, 0);

    // Reverse with an index beyond a shortened length.
    for (int i = 0; i < 3; i++) run(1, 0, 0, 7, 0);
    run(1, 1, 0, 2, 0);
    run(1, 1, 0, 2, 0);

    // Randomized run: all controls vary, with rare mid-run clears.
    begin
      bit r_dir, r_mode;
      int r_len;
      r_dir = 0; r_mode = 0; r_len = 7;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 7) == 0) r_dir = ~r_dir;
        if ($urandom_range(0, 15) == 0) r_mode = ~r_mode;
        if ($urandom_range(0, 11) == 0) r_len = int'($urandom_range(0, 7));
        applyStimulus(1, ($urandom_range(0, 59) == 0),
                      ($urandom_range(0, 3) != 0), r_dir, r_mode, r_len,
                      ($urandom_range(0, 24) == 0),
                      ($urandom_range(0, 3) == 0),
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
      end
    end

    repeat (2) @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      n_miscompares++;
      $display("[TB] FAIL drain: got %0d pending entries expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
